// File: rtl/adi_cfg_seq_if.sv
// Bus bundle between the configuration sequencer, its init ROM,
// the system controller and the ADI SPI master.
// The master modport is the sequencer's view; the slave modport is the
// view of everything around it (controller, ROM and SPI master).
interface adi_cfg_seq_if #(
    parameter int unsigned IDX_W = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] err_index;

    logic [IDX_W-1:0] lut_index;
    logic [19:0]      lut_data;

    logic             wr_req;
    logic [9:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             wr_end;

    logic             rd_req;
    logic [9:0]       rd_addr;
    logic [7:0]       rd_data;
    logic             rd_end;

    modport master (
        input  start, lut_data, wr_end, rd_data, rd_end,
        output busy, done, error, err_index, lut_index,
               wr_req, wr_addr, wr_data, rd_req, rd_addr
    );

    modport slave (
        output start, lut_data, wr_end, rd_data, rd_end,
        input  busy, done, error, err_index, lut_index,
               wr_req, wr_addr, wr_data, rd_req, rd_addr
    );
endinterface

// File: rtl/adi_cfg_seq.sv
// Table-driven register configuration sequencer.
// Walks a synchronous init ROM one entry at a time and turns each entry
// into SPI write / read transactions: plain write, write with readback
// verify, or a read-poll until masked bits are set. A table entry with
// op 11 (or running off the last table slot) finishes the sequence.
// Every request is separated from the previous completion by a fixed
// idle gap so the SPI chip select stays high long enough.
module adi_cfg_seq #(
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned GAP_CYC  = 64,
    parameter int unsigned POLL_MAX = 1000
) (
    input logic            clk,
    input logic            rst,
    adi_cfg_seq_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR,
        S_WR_WAIT,
        S_RD,
        S_RD_WAIT,
        S_CHECK,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [1:0]       OP_WRITE_VERIFY = 2'b01;
    localparam logic [1:0]       OP_POLL         = 2'b10;
    localparam logic [1:0]       OP_END          = 2'b11;
    localparam logic [15:0]      GAP_LAST        = 16'(GAP_CYC - 1);
    localparam logic [15:0]      POLL_LIMIT      = 16'(POLL_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST        = '1;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [9:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_rdCap;
    logic        r_verify;
    logic        r_retry;
    logic [15:0] r_gapCnt;
    logic [15:0] r_pollCnt;

    logic [15:0] w_pollNext;
    logic        w_pollHit;
    logic        w_verifyOk;
    logic        w_atLast;

    assign w_pollNext = r_pollCnt + 16'd1;
    assign w_pollHit  = ((r_rdCap & r_data) == r_data);
    assign w_verifyOk = (r_rdCap == r_data);
    assign w_atLast   = (bus.lut_index == IDX_LAST);

    // Sequencer FSM; all bus outputs are registered here, request and done are one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_addr        <= 10'd0;
            r_data        <= 8'd0;
            r_rdCap       <= 8'd0;
            r_verify      <= 1'b0;
            r_retry       <= 1'b0;
            r_gapCnt      <= 16'd0;
            r_pollCnt     <= 16'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.err_index <= '0;
            bus.lut_index <= '0;
            bus.wr_req    <= 1'b0;
            bus.wr_addr   <= 10'd0;
            bus.wr_data   <= 8'd0;
            bus.rd_req    <= 1'b0;
            bus.rd_addr   <= 10'd0;
        end else begin
            bus.done   <= 1'b0;
            bus.wr_req <= 1'b0;
            bus.rd_req <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.lut_index <= '0;
                        bus.error     <= 1'b0;
                        bus.busy      <= 1'b1;
                        r_pollCnt     <= 16'd0;
                        r_verify      <= 1'b0;
                        r_retry       <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    r_op   <= bus.lut_data[19:18];
                    r_addr <= bus.lut_data[17:8];
                    r_data <= bus.lut_data[7:0];
                    case (bus.lut_data[19:18])
                        OP_END: begin
                            r_state <= S_FIN;
                        end
                        OP_POLL: begin
                            bus.rd_req  <= 1'b1;
                            bus.rd_addr <= bus.lut_data[17:8];
                            r_state     <= S_RD;
                        end
                        default: begin
                            bus.wr_req  <= 1'b1;
                            bus.wr_addr <= bus.lut_data[17:8];
                            bus.wr_data <= bus.lut_data[7:0];
                            r_state     <= S_WR;
                        end
                    endcase
                end

                S_WR: begin
                    r_state <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (bus.wr_end) begin
                        r_gapCnt <= 16'd0;
                        if (r_op == OP_WRITE_VERIFY) begin
                            r_verify <= 1'b1;
                            r_state  <= S_GAP;
                        end else if (w_atLast) begin
                            r_state <= S_FIN;
                        end else begin
                            bus.lut_index <= bus.lut_index + 1'b1;
                            r_state       <= S_GAP;
                        end
                    end
                end

                S_RD: begin
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (bus.rd_end) begin
                        r_rdCap <= bus.rd_data;
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    r_gapCnt <= 16'd0;
                    if ((r_op == OP_POLL) ? w_pollHit : w_verifyOk) begin
                        r_pollCnt <= 16'd0;
                        r_verify  <= 1'b0;
                        if (w_atLast) begin
                            r_state <= S_FIN;
                        end else begin
                            bus.lut_index <= bus.lut_index + 1'b1;
                            r_state       <= S_GAP;
                        end
                    end else if ((r_op == OP_POLL) && (w_pollNext != POLL_LIMIT)) begin
                        r_pollCnt <= w_pollNext;
                        r_retry   <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        bus.error     <= 1'b1;
                        bus.err_index <= bus.lut_index;
                        bus.busy      <= 1'b0;
                        r_verify      <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end

                S_GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        if (r_verify || r_retry) begin
                            r_retry     <= 1'b0;
                            bus.rd_req  <= 1'b1;
                            bus.rd_addr <= r_addr;
                            r_state     <= S_RD;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_gapCnt <= r_gapCnt + 16'd1;
                    end
                end

                S_FIN: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adi_cfg_seq.sv
// Self-checking bench for adi_cfg_seq.
// A synchronous ROM and a behavioural SPI master surround the sequencer;
// an abstract table-walk model predicts the ordered transaction list,
// done/error outcome and failing index for each table.
module tb_adi_cfg_seq;

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned GAP_CYC  = 4;
    localparam int unsigned POLL_MAX = 5;
    localparam int          DEPTH    = 1 << IDX_W;
    localparam int          RUN_LIMIT = 3000;

    typedef logic [18:0] txn_t;   // {isRead, addr[9:0], data[7:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;

    adi_cfg_seq_if #(.IDX_W(IDX_W)) bus ();

    adi_cfg_seq #(
        .IDX_W   (IDX_W),
        .GAP_CYC (GAP_CYC),
        .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [19:0] rom [DEPTH];
    logic [7:0]  rdResp [$];
    txn_t        expTxn [$];
    txn_t        gotTxn [$];
    logic        expDone;
    logic        expErr;
    int          expErrIdx;

    int  vectors     = 0;
    int  miscompares = 0;

    int  cycle        = 0;
    bit  pending      = 0;
    bit  pendRd       = 0;
    logic [9:0] pendAddr = '0;
    int  delay        = 0;
    int  fixedDelay   = -1;
    bit  strayWrReq   = 0;
    bit  strayRdInWr  = 0;
    int  lastEndCycle = 0;
    int  endCount     = 0;
    int  doneCount    = 0;
    int  violations   = 0;

    // Synchronous init ROM: data follows the index one clock later
    always @(posedge clk) bus.lut_data <= rom[bus.lut_index];

    // Free-running cycle count used to measure request spacing
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural SPI master: completes each request after a short delay and polices the protocol
    initial begin : spiSlave
        logic [7:0] v;
        bus.wr_end  = 1'b0;
        bus.rd_end  = 1'b0;
        bus.rd_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.wr_end = 1'b0;
            bus.rd_end = 1'b0;
            if (rst) begin
                pending = 0;
            end else begin
                if (bus.done === 1'b1) doneCount++;
                if (pending) begin
                    if (delay == 0) begin
                        pending      = 0;
                        endCount++;
                        lastEndCycle = cycle;
                        if (pendRd) begin
                            v = (rdResp.size() > 0) ? rdResp.pop_front() : 8'h00;
                            bus.rd_data = v;
                            bus.rd_end  = 1'b1;
                            gotTxn.push_back({1'b1, pendAddr, v});
                        end else begin
                            bus.wr_end = 1'b1;
                        end
                    end else begin
                        delay--;
                        if (strayRdInWr && !pendRd) begin
                            bus.rd_end  = 1'b1;
                            strayRdInWr = 0;
                        end
                    end
                end else if (strayWrReq) begin
                    bus.wr_end = 1'b1;
                    strayWrReq = 0;
                end
                if (bus.wr_req === 1'b1 || bus.rd_req === 1'b1) begin
                    if (bus.wr_req === 1'b1 && bus.rd_req === 1'b1) violations++;
                    if (pending) violations++;
                    if (endCount > 0 && (cycle - lastEndCycle) < int'(GAP_CYC) + 1) violations++;
                    pending  = 1;
                    pendRd   = (bus.rd_req === 1'b1);
                    pendAddr = pendRd ? bus.rd_addr : bus.wr_addr;
                    delay    = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
                    if (!pendRd) gotTxn.push_back({1'b0, bus.wr_addr, bus.wr_data});
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < DEPTH; i++) rom[i] = {2'b11, 18'h0};
        rdResp.delete();
    endtask

    // Reference model: walks the table by the op-code rules, consuming read responses in order
    task automatic computeExpected();
        logic [7:0] resp [$];
        logic [1:0] op;
        logic [9:0] a;
        logic [7:0] d;
        logic [7:0] v;
        int         tries;
        resp = rdResp;
        expTxn.delete();
        expDone   = 1'b0;
        expErr    = 1'b0;
        expErrIdx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = rom[i][19:18];
            a  = rom[i][17:8];
            d  = rom[i][7:0];
            if (op == 2'b11) begin
                expDone = 1'b1;
                return;
            end
            if (op != 2'b10) expTxn.push_back({1'b0, a, d});
            if (op == 2'b01) begin
                v = (resp.size() > 0) ? resp.pop_front() : 8'h00;
                expTxn.push_back({1'b1, a, v});
                if (v != d) begin
                    expErr    = 1'b1;
                    expErrIdx = i;
                    return;
                end
            end else if (op == 2'b10) begin
                tries = 0;
                while (1'b1) begin
                    v = (resp.size() > 0) ? resp.pop_front() : 8'h00;
                    expTxn.push_back({1'b1, a, v});
                    tries++;
                    if ((v & d) == d) break;
                    if (tries == int'(POLL_MAX)) begin
                        expErr    = 1'b1;
                        expErrIdx = i;
                        return;
                    end
                end
            end
        end
        expDone = 1'b1;
    endtask

    // Runs one whole sequence from a start pulse and compares it with the model
    task automatic applyStimulus(input string name, input int hook);
        int   waited;
        logic timedOut;
        int   hookStage;
        int   n;
        computeExpected();
        gotTxn.delete();
        endCount   = 0;
        doneCount  = 0;
        violations = 0;
        hookStage  = 0;
        $display("[TB] running %s", name);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({name, ".busyAfterStart"}, {31'd0, bus.busy}, 32'd1);
        checkOutput({name, ".errorClearedByStart"}, {31'd0, bus.error}, 32'd0);
        waited   = 0;
        timedOut = 1'b0;
        forever begin
            if (bus.done === 1'b1 || bus.error === 1'b1) break;
            if (waited >= RUN_LIMIT) begin
                timedOut = 1'b1;
                break;
            end
            if (hook == 1) begin
                if (hookStage == 0 && endCount >= 1 && cycle >= lastEndCycle + 1) begin
                    bus.start  = 1'b1;
                    strayWrReq = 1;
                    hookStage  = 1;
                end else if (hookStage == 1) begin
                    bus.start = 1'b0;
                    hookStage = 2;
                end
            end
            @(negedge clk);
            waited++;
        end
        bus.start = 1'b0;
        checkOutput({name, ".timeout"}, {31'd0, timedOut}, 32'd0);
        checkOutput({name, ".error"}, {31'd0, bus.error}, {31'd0, expErr});
        if (expErr) checkOutput({name, ".errIndex"}, 32'(bus.err_index), 32'(expErrIdx));
        @(negedge clk);
        checkOutput({name, ".busyAtEnd"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({name, ".donePulseWidth"}, {31'd0, bus.done}, 32'd0);
        checkOutput({name, ".errorHeld"}, {31'd0, bus.error}, {31'd0, expErr});
        checkOutput({name, ".doneCount"}, 32'(doneCount), expDone ? 32'd1 : 32'd0);
        checkOutput({name, ".txnCount"}, 32'(gotTxn.size()), 32'(expTxn.size()));
        n = (gotTxn.size() < expTxn.size()) ? gotTxn.size() : expTxn.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.txn%0d", name, i), 32'(gotTxn[i]), 32'(expTxn[i]));
        checkOutput({name, ".protocol"}, 32'(violations), 32'd0);
    endtask

    // Random table: ops 00..10 with random length, read responses biased to exercise pass and fail
    task automatic buildRandom();
        int          len;
        int          k;
        logic [1:0]  op;
        logic [9:0]  a;
        logic [7:0]  d;
        logic [7:0]  bitv;
        clearRom();
        len = $urandom_range(1, DEPTH);
        for (int i = 0; i < len; i++) begin
            op   = 2'($urandom_range(0, 2));
            a    = 10'($urandom);
            d    = 8'($urandom);
            bitv = 8'h01 << $urandom_range(0, 7);
            if (op == 2'b01) begin
                rdResp.push_back(($urandom_range(0, 3) == 0) ? (d ^ bitv) : d);
            end else if (op == 2'b10) begin
                d = d | bitv;
                k = $urandom_range(0, POLL_MAX);
                for (int j = 0; j < k; j++) rdResp.push_back(8'($urandom) & ~d);
                if (k < int'(POLL_MAX)) rdResp.push_back(8'($urandom) | d);
            end
            rom[i] = {op, a, d};
        end
    endtask

    initial begin : directed
        int waited;
        bus.start = 1'b0;
        clearRom();

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy",      {31'd0, bus.busy},   32'd0);
        checkOutput("reset.done",      {31'd0, bus.done},   32'd0);
        checkOutput("reset.error",     {31'd0, bus.error},  32'd0);
        checkOutput("reset.errIndex",  32'(bus.err_index),  32'd0);
        checkOutput("reset.lutIndex",  32'(bus.lut_index),  32'd0);
        checkOutput("reset.wrReq",     {31'd0, bus.wr_req}, 32'd0);
        checkOutput("reset.rdReq",     {31'd0, bus.rd_req}, 32'd0);
        checkOutput("reset.wrAddr",    32'(bus.wr_addr),    32'd0);
        checkOutput("reset.wrData",    32'(bus.wr_data),    32'd0);
        checkOutput("reset.rdAddr",    32'(bus.rd_addr),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two plain writes then END
        clearRom();
        rom[0] = {2'b00, 10'h000, 8'h81};
        rom[1] = {2'b00, 10'h3F4, 8'h05};
        applyStimulus("twoWrites", 0);

        // Write-verify that reads back correctly
        clearRom();
        rom[0] = {2'b01, 10'h014, 8'hAA};
        rdResp.push_back(8'hAA);
        applyStimulus("verifyPass", 0);

        // Write-verify that reads back wrong
        clearRom();
        rom[0] = {2'b01, 10'h014, 8'hAA};
        rdResp.push_back(8'hAB);
        applyStimulus("verifyFail", 0);

        // Poll succeeding on the fourth read
        clearRom();
        rom[0] = {2'b10, 10'h05E, 8'h80};
        rdResp = '{8'h00, 8'h00, 8'h00, 8'h80};
        applyStimulus("pollPass", 0);

        // Poll that never matches: exactly POLL_MAX reads then error
        clearRom();
        rom[0] = {2'b10, 10'h05E, 8'h80};
        for (int i = 0; i < 8; i++) rdResp.push_back(8'h00);
        applyStimulus("pollExhaust", 0);

        // Poll failing on a later entry reports that entry's index
        clearRom();
        rom[0] = {2'b00, 10'h001, 8'h11};
        rom[1] = {2'b00, 10'h002, 8'h22};
        rom[2] = {2'b10, 10'h003, 8'h0C};
        for (int i = 0; i < 8; i++) rdResp.push_back(8'h04);
        applyStimulus("pollFailIdx2", 0);

        // Full table without END: stops at the last slot, no wrap
        clearRom();
        for (int i = 0; i < DEPTH; i++) rom[i] = {2'b00, 10'(i * 37 + 5), 8'(i * 13 + 1)};
        applyStimulus("fullTable", 0);
        checkOutput("fullTable.lastIndex", 32'(bus.lut_index), 32'(DEPTH - 1));

        // Reset while waiting for wr_end, then a clean rerun
        clearRom();
        rom[0] = {2'b00, 10'h000, 8'h81};
        rom[1] = {2'b00, 10'h3F4, 8'h05};
        fixedDelay = 8;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waited = 0;
        while (bus.wr_req !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midReset.wrReqSeen", {31'd0, bus.wr_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset.wrReq",    {31'd0, bus.wr_req}, 32'd0);
        checkOutput("midReset.busy",     {31'd0, bus.busy},   32'd0);
        checkOutput("midReset.error",    {31'd0, bus.error},  32'd0);
        checkOutput("midReset.lutIndex", 32'(bus.lut_index),  32'd0);
        rst = 1'b0;
        fixedDelay = -1;
        repeat (2) @(negedge clk);
        applyStimulus("afterReset", 0);

        // Start while busy, stray wr_end in the gap, stray rd_end while waiting for a write
        clearRom();
        rom[0] = {2'b00, 10'h000, 8'h81};
        rom[1] = {2'b00, 10'h3F4, 8'h05};
        fixedDelay  = 3;
        strayRdInWr = 1;
        applyStimulus("strayPulses", 1);
        fixedDelay  = -1;
        strayRdInWr = 0;
        strayWrReq  = 0;

        // Randomized tables
        for (int r = 0; r < 8; r++) begin
            buildRandom();
            applyStimulus($sformatf("random%0d", r), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
